// File: rtl/asm_coord_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : asm_coord_scanner
//  Purpose  : Walks every cell of a ROWS x COLS grid, one cell per beat,
//             presenting each cell to the alpha_ref lookup. Every lit cell
//             is emitted as a (row,col) coordinate on a valid/ready
//             handshake, and the number of lit cells is counted.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i          system clock, rising edge
//    reset_i        asynchronous active-high reset
//    start_i        level; begins a scan from IDLE or DONE
//    beat_i         one-clk strobe pacing the scan
//    hit_i          lookup result for (scan_row_o, scan_col_o), same cycle
//    coord_ready_i  consumer accepts the current coordinate
//    scan_row_o     row presented to the lookup
//    scan_col_o     column presented to the lookup
//    coord_valid_o  coordinate available
//    coord_row_o    row of the lit cell, stable while coord_valid_o=1
//    coord_col_o    column of the lit cell, stable while coord_valid_o=1
//    hit_count_o    lit cells found in the current / last scan
//    busy_o         1 while scanning or emitting
//    done_o         1 once the scan has finished
//    state_led_o    encoded state
// ============================================================================
module asm_coord_scanner #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int CW   = 3,
    parameter int NW   = 7
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          beat_i,
    input  logic          hit_i,
    input  logic          coord_ready_i,
    output logic [CW-1:0] scan_row_o,
    output logic [CW-1:0] scan_col_o,
    output logic          coord_valid_o,
    output logic [CW-1:0] coord_row_o,
    output logic [CW-1:0] coord_col_o,
    output logic [NW-1:0] hit_count_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [1:0]    state_led_o
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SCAN = 2'b01;
    localparam logic [1:0] ST_EMIT = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    localparam logic [CW-1:0] C_LAST_ROW = CW'(ROWS - 1);
    localparam logic [CW-1:0] C_LAST_COL = CW'(COLS - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] coord_row_q, coord_row_d;
    logic [CW-1:0] coord_col_q, coord_col_d;
    logic          coord_valid_q, coord_valid_d;
    logic [NW-1:0] hit_count_q, hit_count_d;

    logic w_last_cell;
    logic w_start;
    logic w_take_hit;
    logic w_advance;

    assign w_last_cell = (row_q == C_LAST_ROW) && (col_q == C_LAST_COL);
    assign w_start     = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_i;
    assign w_take_hit  = (state_q == ST_SCAN) && beat_i && hit_i;
    // The cursor moves either on a miss or when the pending coordinate is
    // accepted; beats arriving during EMIT are deliberately dropped.
    assign w_advance   = ((state_q == ST_SCAN) && beat_i && !hit_i) ||
                         ((state_q == ST_EMIT) && coord_valid_q && coord_ready_i);

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_SCAN;
            ST_SCAN: begin
                if (w_take_hit)     state_d = ST_EMIT;
                else if (w_advance) state_d = w_last_cell ? ST_DONE : ST_SCAN;
            end
            ST_EMIT: if (w_advance) state_d = w_last_cell ? ST_DONE : ST_SCAN;
            ST_DONE: if (start_i) state_d = ST_SCAN;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- state-derived outputs ----------------
    always_comb begin
        busy_o      = (state_q == ST_SCAN) || (state_q == ST_EMIT);
        done_o      = (state_q == ST_DONE);
        state_led_o = state_q;
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        row_d         = row_q;
        col_d         = col_q;
        coord_row_d   = coord_row_q;
        coord_col_d   = coord_col_q;
        coord_valid_d = coord_valid_q;
        hit_count_d   = hit_count_q;

        if (w_start) begin
            row_d       = '0;
            col_d       = '0;
            hit_count_d = '0;
        end

        if (w_take_hit) begin
            coord_row_d   = row_q;
            coord_col_d   = col_q;
            coord_valid_d = 1'b1;
            if (!(&hit_count_q)) begin
                hit_count_d = hit_count_q + 1'b1;
            end
        end

        if (w_advance) begin
            if ((state_q == ST_EMIT)) begin
                coord_valid_d = 1'b0;
            end
            // Row-major walk; after the last cell the cursor parks at (0,0).
            if (w_last_cell) begin
                row_d = '0;
                col_d = '0;
            end else if (col_q == C_LAST_COL) begin
                row_d = row_q + 1'b1;
                col_d = '0;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            row_q         <= '0;
            col_q         <= '0;
            coord_row_q   <= '0;
            coord_col_q   <= '0;
            coord_valid_q <= 1'b0;
            hit_count_q   <= '0;
        end else begin
            row_q         <= row_d;
            col_q         <= col_d;
            coord_row_q   <= coord_row_d;
            coord_col_q   <= coord_col_d;
            coord_valid_q <= coord_valid_d;
            hit_count_q   <= hit_count_d;
        end
    end

    assign scan_row_o    = row_q;
    assign scan_col_o    = col_q;
    assign coord_row_o   = coord_row_q;
    assign coord_col_o   = coord_col_q;
    assign coord_valid_o = coord_valid_q;
    assign hit_count_o   = hit_count_q;

endmodule
`default_nettype wire
